// File: rtl/axi_ar_redirect_ctrl_if.sv
// Configuration port of the AR redirect-table controller.
// The config master raises cfg_req with a single table entry. It holds the
// entry fields stable until cfg_gnt. Completion is reported by a one-cycle
// cfg_done pulse. Rejection or abort is reported by a one-cycle cfg_err pulse.
interface axi_ar_redirect_ctrl_if #(
    parameter int LOG_N_INIT = 3
);
    logic                  cfg_req;
    logic                  cfg_gnt;
    logic [LOG_N_INIT-1:0] cfg_idx;
    logic [LOG_N_INIT-1:0] cfg_source;
    logic [LOG_N_INIT-1:0] cfg_target;
    logic                  cfg_en;
    logic                  cfg_done;
    logic                  cfg_err;

    modport master (
        output cfg_req, cfg_idx, cfg_source, cfg_target, cfg_en,
        input  cfg_gnt, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_req, cfg_idx, cfg_source, cfg_target, cfg_en,
        output cfg_gnt, cfg_done, cfg_err
    );
endinterface

// File: rtl/axi_ar_redirect_ctrl.sv
// Runtime controller for the AR-channel redirect table.
// An accepted update runs the following sequence:
//   1. Block new AR grants at every decoder.
//   2. Wait for outstanding reads to drain, or abort on timeout.
//   3. Write the single entry atomically.
//   4. Release the decoders.
// The table outputs come only from registers, so a decoder never sees a
// partially written mapping.
module axi_ar_redirect_ctrl #(
    parameter int N_INIT_PORT   = 8,
    parameter int LOG_N_INIT    = 3,
    parameter int N_TARG_PORT   = 4,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    axi_ar_redirect_ctrl_if.slave             cfg,
    output logic                              ar_block_o,
    input  logic [N_TARG_PORT-1:0]            outstanding_i,
    output logic [N_INIT_PORT*LOG_N_INIT-1:0] source_o,
    output logic [N_INIT_PORT*LOG_N_INIT-1:0] target_o,
    output logic [N_INIT_PORT-1:0]            redirect_valid_o
);

    // The counter holds cycles elapsed since the block was raised. It is 0
    // in BLOCK and reaches DRAIN_TIMEOUT-1 on the last allowed DRAIN cycle.
    localparam int                    CNT_W    = $clog2(DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [LOG_N_INIT:0]   IDX_LIM  = (LOG_N_INIT + 1)'(N_INIT_PORT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLOCK,
        S_DRAIN,
        S_COMMIT,
        S_RELEASE
    } state_e;

    state_e                  state_q;
    logic [LOG_N_INIT-1:0]   idx_q;
    logic [LOG_N_INIT-1:0]   src_q;
    logic [LOG_N_INIT-1:0]   tgt_q;
    logic                    en_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    block_q;
    logic                    done_q;
    logic                    err_q;
    logic [LOG_N_INIT-1:0]   tbl_src_q [N_INIT_PORT];
    logic [LOG_N_INIT-1:0]   tbl_tgt_q [N_INIT_PORT];
    logic [N_INIT_PORT-1:0]  tbl_vld_q;

    logic                    req_bad_d;
    logic                    drained_d;
    logic                    timeout_d;
    logic [CNT_W-1:0]        cnt_d;

    // A request is unusable when its index is outside the table, or when it
    // enables a redirect that maps a port onto itself.
    assign req_bad_d = ({1'b0, cfg.cfg_idx} >= IDX_LIM) ||
                       (cfg.cfg_en && (cfg.cfg_source == cfg.cfg_target));
    assign drained_d = ~|outstanding_i;
    assign timeout_d = (cnt_q == CNT_LAST);
    assign cnt_d     = cnt_q + 1'b1;

    // Requests are only ever granted while idle.
    assign cfg.cfg_gnt  = cfg.cfg_req && (state_q == S_IDLE);
    assign cfg.cfg_done = done_q;
    assign cfg.cfg_err  = err_q;
    assign ar_block_o   = block_q;

    // Update sequencer: the FSM, its registered pulses, and the table itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            src_q     <= '0;
            tgt_q     <= '0;
            en_q      <= 1'b0;
            cnt_q     <= '0;
            block_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tbl_vld_q <= '0;
            for (int i = 0; i < N_INIT_PORT; i++) begin
                tbl_src_q[i] <= '0;
                tbl_tgt_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg.cfg_req) begin
                        idx_q <= cfg.cfg_idx;
                        src_q <= cfg.cfg_source;
                        tgt_q <= cfg.cfg_target;
                        en_q  <= cfg.cfg_en;
                        if (req_bad_d) begin
                            err_q <= 1'b1;
                        end else begin
                            block_q <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_BLOCK;
                        end
                    end
                end
                S_BLOCK: begin
                    // Give an AR handshake that is already in flight one
                    // cycle to land and raise its outstanding flag.
                    cnt_q   <= cnt_d;
                    state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    // A drain that happens on the last allowed cycle still
                    // commits.
                    if (drained_d) begin
                        state_q <= S_COMMIT;
                    end else if (timeout_d) begin
                        err_q   <= 1'b1;
                        block_q <= 1'b0;
                        state_q <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_COMMIT: begin
                    for (int i = 0; i < N_INIT_PORT; i++) begin
                        if (idx_q == LOG_N_INIT'(i)) begin
                            tbl_src_q[i] <= src_q;
                            tbl_tgt_q[i] <= tgt_q;
                            tbl_vld_q[i] <= en_q;
                        end
                    end
                    // The new entry and the unblock become visible together.
                    done_q  <= 1'b1;
                    block_q <= 1'b0;
                    state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    block_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Flatten the table into the decoder-facing buses.
    for (genvar g = 0; g < N_INIT_PORT; g++) begin : g_flat
        assign source_o[g*LOG_N_INIT +: LOG_N_INIT] = tbl_src_q[g];
        assign target_o[g*LOG_N_INIT +: LOG_N_INIT] = tbl_tgt_q[g];
    end
    assign redirect_valid_o = tbl_vld_q;

endmodule

// File: tb/tb_axi_ar_redirect_ctrl.sv
// Bench for axi_ar_redirect_ctrl.
// It contains a transaction-level model, a per-cycle compare process, and
// directed and randomized request sequences.
module tb_axi_ar_redirect_ctrl;
    localparam int N  = 6;
    localparam int LW = 3;
    localparam int NT = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_ar_redirect_ctrl_if #(.LOG_N_INIT(LW)) cfg_if ();

    logic              ar_block;
    logic [NT-1:0]     outstanding;
    logic [N*LW-1:0]   src_o;
    logic [N*LW-1:0]   tgt_o;
    logic [N-1:0]      vld_o;

    axi_ar_redirect_ctrl #(
        .N_INIT_PORT  (N),
        .LOG_N_INIT   (LW),
        .N_TARG_PORT  (NT),
        .DRAIN_TIMEOUT(TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg             (cfg_if.slave),
        .ar_block_o      (ar_block),
        .outstanding_i   (outstanding),
        .source_o        (src_o),
        .target_o        (tgt_o),
        .redirect_valid_o(vld_o)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Outstanding-read driver:
    //   mode 0 drives all zeros.
    //   mode 1 holds out_val until cycle out_until, then zero.
    //   mode 2 drives random values.
    int            out_mode  = 0;
    logic [NT-1:0] out_val   = '0;
    int            out_until = 0;
    always @(posedge clk) begin
        #2;
        case (out_mode)
            0:       outstanding = '0;
            1:       outstanding = (cyc < out_until) ? out_val : '0;
            default: outstanding = ($urandom_range(0, 2) == 0) ? '0 : NT'($urandom);
        endcase
    end

    // Transaction-level model. An update granted in cycle g proceeds as follows:
    //   - It blocks from g+1.
    //   - It looks for the first cycle c >= g+2 with no outstanding reads.
    //   - It commits in c+1, shows the entry and done in c+2, and is idle in c+3.
    //   - If outstanding never clears by cycle g+TO, err is shown in g+TO+1
    //     and the model is idle in g+TO+2.
    logic [N*LW-1:0] m_src, m_tgt;
    logic [N-1:0]    m_vld;
    bit              m_busy, m_resolved, m_block, m_done, m_err;
    int              m_g, m_commit, m_release;
    logic [LW-1:0]   c_idx, c_src, c_tgt;
    logic            c_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_src = '0; m_tgt = '0; m_vld = '0;
            m_busy = 0; m_resolved = 0; m_block = 0; m_done = 0; m_err = 0;
            m_g = 0; m_commit = -1; m_release = -1;
        end else begin
            m_done = 0;
            m_err  = 0;
            if (!m_busy) begin
                if (cfg_if.cfg_req) begin
                    if ((int'(cfg_if.cfg_idx) >= N) ||
                        (cfg_if.cfg_en && cfg_if.cfg_source == cfg_if.cfg_target)) begin
                        m_err = 1;
                    end else begin
                        m_busy = 1; m_resolved = 0; m_g = cyc;
                        m_commit = -1; m_release = -1; m_block = 1;
                        c_idx = cfg_if.cfg_idx; c_src = cfg_if.cfg_source;
                        c_tgt = cfg_if.cfg_target; c_en = cfg_if.cfg_en;
                    end
                end
            end else if (cyc == m_release) begin
                m_busy = 0;
            end else if (cyc == m_commit) begin
                m_src[int'(c_idx)*LW +: LW] = c_src;
                m_tgt[int'(c_idx)*LW +: LW] = c_tgt;
                m_vld[c_idx] = c_en;
                m_done = 1; m_block = 0; m_release = cyc + 1;
            end else if (!m_resolved && (cyc - m_g) >= 2) begin
                if (outstanding == '0) begin
                    m_resolved = 1; m_commit = cyc + 1;
                end else if ((cyc - m_g) == TO) begin
                    m_resolved = 1; m_err = 1; m_block = 0; m_release = cyc + 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("gnt",   cfg_if.cfg_gnt,  cfg_if.cfg_req && !m_busy);
            check("block", ar_block,        m_block);
            check("done",  cfg_if.cfg_done, m_done);
            check("err",   cfg_if.cfg_err,  m_err);
            check("src",   src_o,           m_src);
            check("tgt",   tgt_o,           m_tgt);
            check("vld",   vld_o,           m_vld);
        end
    end

    // Raise a request, hold it until granted (bounded), and scramble the
    // fields afterwards. Returns at 2 time units into cycle g+1.
    task automatic do_req(input logic [LW-1:0] idx, input logic [LW-1:0] src,
                          input logic [LW-1:0] tgt, input logic en, output int g);
        bit ok;
        ok = 0;
        g  = -1;
        cfg_if.cfg_idx = idx; cfg_if.cfg_source = src;
        cfg_if.cfg_target = tgt; cfg_if.cfg_en = en;
        cfg_if.cfg_req = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cfg_if.cfg_gnt) begin
                g = cyc; ok = 1;
                break;
            end
        end
        @(posedge clk); #2;
        cfg_if.cfg_req = 1'b0;
        cfg_if.cfg_idx = LW'($urandom); cfg_if.cfg_source = LW'($urandom);
        cfg_if.cfg_target = LW'($urandom); cfg_if.cfg_en = 1'($urandom);
        check("grant_wait", ok, 1'b1);
    endtask

    task automatic next_cycle();
        @(posedge clk); #2;
    endtask

    int              g, ga, gb;
    logic [N-1:0]    vld_save;
    logic [LW-1:0]   r_idx, r_src, r_tgt;

    initial begin
        cfg_if.cfg_req = 0; cfg_if.cfg_idx = '0; cfg_if.cfg_source = '0;
        cfg_if.cfg_target = '0; cfg_if.cfg_en = 0;
        outstanding = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_block", ar_block, 1'b0);
        check("rst_done",  cfg_if.cfg_done, 1'b0);
        check("rst_err",   cfg_if.cfg_err, 1'b0);
        check("rst_src",   src_o, '0);
        check("rst_tgt",   tgt_o, '0);
        check("rst_vld",   vld_o, '0);
        rst_n = 1'b1;
        chk_en = 1;
        next_cycle();

        // Minimum-latency commit: idx=2, src=1, tgt=5, en=1.
        out_mode = 0;
        do_req(3'd2, 3'd1, 3'd5, 1'b1, g);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t1_block", ar_block, (k <= 3) ? 1'b1 : 1'b0);
            check("t1_done",  cfg_if.cfg_done, (k == 4) ? 1'b1 : 1'b0);
            check("t1_vld2",  vld_o[2], (k == 4) ? 1'b1 : 1'b0);
        end
        check("t1_src2", src_o[2*LW +: LW], 3'd1);
        check("t1_tgt2", tgt_o[2*LW +: LW], 3'd5);
        next_cycle();

        // Drain held off by outstanding_i=4'b0010 for 10 cycles after grant.
        out_mode = 1; out_val = 4'b0010; out_until = cyc + 11;
        do_req(3'd4, 3'd3, 3'd0, 1'b1, g);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            check("t2_block", ar_block, (k <= 12) ? 1'b1 : 1'b0);
            check("t2_done",  cfg_if.cfg_done, (k == 13) ? 1'b1 : 1'b0);
        end
        check("t2_vld", vld_o, 6'b010100);
        check("t2_src4", src_o[4*LW +: LW], 3'd3);
        next_cycle();

        // Drain timeout with outstanding stuck high.
        vld_save = vld_o;
        out_mode = 1; out_val = 4'b0001; out_until = cyc + 100000;
        do_req(3'd1, 3'd2, 3'd3, 1'b1, g);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            check("t3_err",   cfg_if.cfg_err, (k == 17) ? 1'b1 : 1'b0);
            check("t3_block", ar_block, (k <= 16) ? 1'b1 : 1'b0);
        end
        check("t3_vld", vld_o, vld_save);
        out_mode = 0;
        next_cycle();
        do_req(3'd1, 3'd2, 3'd3, 1'b1, g);
        repeat (4) next_cycle();
        check("t3_retry_vld", vld_o, 6'b010110);

        // Rejected requests: index out of range, or a self-map with en=1.
        do_req(3'd7, 3'd0, 3'd1, 1'b1, g);
        @(negedge clk);
        check("t4a_err",   cfg_if.cfg_err, 1'b1);
        check("t4a_block", ar_block, 1'b0);
        next_cycle();
        do_req(3'd3, 3'd3, 3'd3, 1'b1, g);
        @(negedge clk);
        check("t4b_err",   cfg_if.cfg_err, 1'b1);
        check("t4b_block", ar_block, 1'b0);
        next_cycle();
        do_req(3'd6, 3'd1, 3'd2, 1'b0, g);
        next_cycle();
        do_req(3'd3, 3'd3, 3'd3, 1'b0, g);
        repeat (5) next_cycle();

        // A second request raised during DRAIN waits for IDLE, then commits.
        out_mode = 1; out_val = 4'b1000; out_until = cyc + 8;
        do_req(3'd5, 3'd4, 3'd6, 1'b1, ga);
        next_cycle();
        do_req(3'd0, 3'd7, 3'd1, 1'b1, gb);
        check("t5_gb", gb - ga, 11);
        repeat (5) next_cycle();
        check("t5_vld", vld_o, 6'b110111);
        check("t5_src0", src_o[0 +: LW], 3'd7);

        // Randomized traffic.
        out_mode = 2;
        for (int it = 0; it < 40; it++) begin
            r_idx = LW'($urandom); r_src = LW'($urandom); r_tgt = LW'($urandom);
            if ($urandom_range(0, 3) == 0) r_tgt = r_src;
            do_req(r_idx, r_src, r_tgt, ($urandom_range(0, 3) != 0), g);
            repeat ($urandom_range(0, 3)) next_cycle();
        end
        out_mode = 0;
        repeat (25) next_cycle();

        // Asynchronous reset in the middle of DRAIN.
        out_mode = 1; out_val = 4'b0100; out_until = cyc + 100000;
        do_req(3'd4, 3'd1, 3'd1, 1'b0, g);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_block", ar_block, 1'b0);
        check("t6_vld",   vld_o, '0);
        check("t6_src",   src_o, '0);
        check("t6_tgt",   tgt_o, '0);
        check("t6_done",  cfg_if.cfg_done, 1'b0);
        check("t6_err",   cfg_if.cfg_err, 1'b0);
        out_mode = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) next_cycle();
        do_req(3'd0, 3'd2, 3'd4, 1'b1, g);
        repeat (5) next_cycle();
        check("t6_after_vld", vld_o, 6'b000001);
        check("t6_after_tgt", tgt_o[0 +: LW], 3'd4);

        repeat (3) next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
